// File: rtl/hough_frame_formatter_if.sv
// Bus bundle for the Hough output formatter: show-ahead FIFO pop side,
// overlay request, and the VIP write/stall output side with status.
interface hough_frame_formatter_if;
   logic        img_out_empty;
   logic [7:0]  img_out_dout;
   logic        img_out_rd_en;
   logic        overlay_en;
   logic        stall_out;
   logic        write;
   logic [23:0] data_out;
   logic        end_of_video_out;
   logic        frame_busy;
   logic [15:0] frame_count;

   modport master (
      input  img_out_empty, img_out_dout, overlay_en, stall_out,
      output img_out_rd_en, write, data_out, end_of_video_out, frame_busy, frame_count
   );

   modport slave (
      output img_out_empty, img_out_dout, overlay_en, stall_out,
      input  img_out_rd_en, write, data_out, end_of_video_out, frame_busy, frame_count
   );
endinterface

// File: rtl/hough_frame_formatter.sv
// Pops processed pixels from the Hough output FIFO, tags end-of-frame, maps
// to RGB with optional red overlay and feeds the VIP port via a 2-entry skid.
module hough_frame_formatter #(
   parameter int          WIDTH          = 512,
   parameter int          HEIGHT         = 288,
   parameter logic [7:0]  OVERLAY_THRESH = 8'd128
) (
   input  logic clk,
   input  logic rst,
   hough_frame_formatter_if.master bus
);
   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   typedef struct packed {
      logic        eov;
      logic [23:0] rgb;
   } entry_t;

   state_t        state_q, state_d;
   logic [1:0]    count_q, count_d;
   entry_t        buf0_q, buf0_d, buf1_q, buf1_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          ovl_q, ovl_d;
   logic [15:0]   frame_count_q, frame_count_d;

   logic   pop, accept, write, last_col, last_px, frame_start, ovl_use;
   entry_t new_e;

   // rd_en is held low during reset so nothing is popped into a buffer being cleared
   assign pop    = ~rst & ~bus.img_out_empty & (count_q < 2'd2);
   assign write  = (count_q != 2'd0);
   assign accept = write & ~bus.stall_out;

   assign bus.img_out_rd_en    = pop;
   assign bus.write            = write;
   assign bus.data_out         = buf0_q.rgb;
   assign bus.end_of_video_out = buf0_q.eov;
   assign bus.frame_busy       = (state_q == ACTIVE);
   assign bus.frame_count      = frame_count_q;

   always_comb begin
      last_col    = (col_q == COL_LAST);
      last_px     = last_col && (row_q == ROW_LAST);
      frame_start = (state_q == IDLE) && (col_q == '0) && (row_q == '0);
      // the first pixel of a frame already uses the freshly sampled overlay request
      ovl_use     = frame_start ? bus.overlay_en : ovl_q;
      new_e.eov   = last_px;
      new_e.rgb   = (ovl_use && (bus.img_out_dout >= OVERLAY_THRESH)) ? 24'hFF0000
                                                                     : {3{bus.img_out_dout}};
   end

   always_comb begin
      state_d = state_q;
      ovl_d   = ovl_q;
      col_d   = col_q;
      row_d   = row_q;
      if (pop) begin
         if (last_col) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (frame_start) ovl_d = bus.overlay_en;
         unique case (state_q)
            IDLE:    if (frame_start) state_d = last_px ? IDLE : ACTIVE;
            ACTIVE:  if (last_px)     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      unique case ({pop, accept})
         2'b10: begin
            if (count_q == 2'd0) buf0_d = new_e;
            else                 buf1_d = new_e;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
         end
         // pop needs count<2 and accept needs count>0, so the head slot is the only one freed
         2'b11:   buf0_d = new_e;
         default: ;
      endcase
      frame_count_d = frame_count_q + 16'(accept & buf0_q.eov);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         count_q       <= 2'd0;
         buf0_q        <= '0;
         buf1_q        <= '0;
         col_q         <= '0;
         row_q         <= '0;
         ovl_q         <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         buf0_q        <= buf0_d;
         buf1_q        <= buf1_d;
         col_q         <= col_d;
         row_q         <= row_d;
         ovl_q         <= ovl_d;
         frame_count_q <= frame_count_d;
      end
   end
endmodule

// File: tb/tb_hough_frame_formatter.sv
// Directed bench: a 4x2 formatter for frame/stall/overlay/gap/reset cases and
// a 1x1 formatter for the frame_count wrap.
module tb_hough_frame_formatter;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   hough_frame_formatter_if a ();
   hough_frame_formatter_if b ();

   hough_frame_formatter #(.WIDTH(4), .HEIGHT(2), .OVERLAY_THRESH(8'd128)) dut_a (
      .clk(clk), .rst(rst_a), .bus(a));
   hough_frame_formatter #(.WIDTH(1), .HEIGHT(1), .OVERLAY_THRESH(8'd128)) dut_b (
      .clk(clk), .rst(rst_b), .bus(b));

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0]  q[$];
   logic [24:0] out_log[$];
   logic        obs_write, obs_eov, obs_rd, obs_busy;
   logic [23:0] obs_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock of the show-ahead FIFO model; starts and ends at a negedge
   task automatic step(input bit gap, input bit stall);
      a.img_out_empty = gap || (q.size() == 0);
      if (q.size() != 0) a.img_out_dout = q[0];
      else               a.img_out_dout = 8'h00;
      a.stall_out = stall;
      #1;
      obs_write = a.write;
      obs_data  = a.data_out;
      obs_eov   = a.end_of_video_out;
      obs_rd    = a.img_out_rd_en;
      obs_busy  = a.frame_busy;
      if (obs_write && !stall) out_log.push_back({obs_eov, obs_data});
      @(posedge clk);
      if (obs_rd) void'(q.pop_front());
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q.size() != 0 || a.write) && n < 40) begin
         step(1'b0, 1'b0);
         n++;
      end
      chk({tag, "_drain"}, 32'(q.size() == 0 && !a.write), 32'd1);
   endtask

   task automatic push_seq(input logic [7:0] base);
      for (int i = 0; i < 8; i++) q.push_back(base + 8'(i));
   endtask

   task automatic check_seq(input string tag, input logic [7:0] base);
      logic [7:0] px;
      chk({tag, "_n"}, out_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < out_log.size(); i++) begin
         px = base + 8'(i);
         chk({tag, "_px"}, out_log[i], {(i == 7), {3{px}}});
      end
   endtask

   logic [7:0]  ovl_px  [8] = '{8'd200, 8'd100, 8'd128, 8'd127, 8'd255, 8'd0, 8'd1, 8'd129};
   logic [23:0] ovl_exp [8] = '{24'hFF0000, 24'h646464, 24'hFF0000, 24'h7F7F7F,
                                24'hFF0000, 24'h000000, 24'h010101, 24'hFF0000};

   initial begin
      logic [7:0] px;
      int n;
      a.img_out_empty = 1'b1; a.img_out_dout = 8'h00; a.overlay_en = 1'b0; a.stall_out = 1'b0;
      b.img_out_empty = 1'b1; b.img_out_dout = 8'h00; b.overlay_en = 1'b0; b.stall_out = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_write", a.write, 1'b0);
      chk("rst_data", a.data_out, 24'h0);
      chk("rst_eov", a.end_of_video_out, 1'b0);
      chk("rst_busy", a.frame_busy, 1'b0);
      chk("rst_fc", a.frame_count, 16'h0);
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);

      // back-to-back frame: 1-cycle latency, 1 pixel/clk
      push_seq(8'h10);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0);
         chk("t1_write", obs_write, (k >= 1 && k <= 8));
         if (k >= 1 && k <= 8) begin
            px = 8'h0F + 8'(k);
            chk("t1_data", obs_data, {3{px}});
            chk("t1_eov", obs_eov, (k == 8));
         end
         if (k == 4) chk("t1_busy", obs_busy, 1'b1);
         if (k == 9) chk("t1_idle", obs_busy, 1'b0);
      end
      chk("t1_fc", a.frame_count, 16'd1);

      // stall: buffer fills to 2, rd_en drops, head held
      out_log.delete();
      push_seq(8'h10);
      step(1'b0, 1'b0);
      for (int j = 0; j < 5; j++) begin
         step(1'b0, 1'b1);
         chk("t2_hold", obs_data, 24'h101010);
         chk("t2_wr", obs_write, 1'b1);
         if (j >= 1) chk("t2_rd", obs_rd, 1'b0);
      end
      drain("t2");
      check_seq("t2", 8'h10);
      chk("t2_fc", a.frame_count, 16'd2);

      // overlay latched at frame start, threshold boundary
      out_log.delete();
      a.overlay_en = 1'b1;
      for (int i = 0; i < 8; i++) q.push_back(ovl_px[i]);
      drain("t3a");
      chk("t3a_n", out_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < out_log.size(); i++)
         chk("t3a_px", out_log[i], {(i == 7), ovl_exp[i]});

      // overlay raised mid-frame has no effect on this frame
      out_log.delete();
      a.overlay_en = 1'b0;
      for (int i = 0; i < 8; i++) q.push_back(8'd200);
      step(1'b0, 1'b0);
      a.overlay_en = 1'b1;
      drain("t3b");
      chk("t3b_n", out_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < out_log.size(); i++)
         chk("t3b_px", out_log[i], {(i == 7), 24'hC8C8C8});

      // next frame picks it up
      out_log.delete();
      q.push_back(8'd200);
      for (int i = 0; i < 7; i++) q.push_back(8'h50);
      drain("t3c");
      chk("t3c_n", out_log.size(), 32'd8);
      if (out_log.size() >= 2) begin
         chk("t3c_red", out_log[0], {1'b0, 24'hFF0000});
         chk("t3c_grey", out_log[1], {1'b0, 24'h505050});
      end
      chk("t3_fc", a.frame_count, 16'd5);
      a.overlay_en = 1'b0;

      // empty gap of 3 cycles between pixel 2 and 3
      out_log.delete();
      push_seq(8'h20);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
         step(1'b1, 1'b0);
         chk("t4_busy", obs_busy, 1'b1);
         if (g >= 1) chk("t4_wr", obs_write, 1'b0);
      end
      drain("t4");
      check_seq("t4", 8'h20);
      chk("t4_fc", a.frame_count, 16'd6);

      // reset after 5 pixels of a frame
      out_log.delete();
      push_seq(8'h30);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      rst_a = 1'b1;
      #1;
      chk("t5_write", a.write, 1'b0);
      chk("t5_data", a.data_out, 24'h0);
      chk("t5_eov", a.end_of_video_out, 1'b0);
      chk("t5_rd", a.img_out_rd_en, 1'b0);
      chk("t5_busy", a.frame_busy, 1'b0);
      chk("t5_fc0", a.frame_count, 16'd0);
      q.delete();
      out_log.delete();
      @(negedge clk);
      rst_a = 1'b0;
      push_seq(8'h40);
      drain("t5");
      check_seq("t5", 8'h40);
      chk("t5_fc1", a.frame_count, 16'd1);

      // 1x1 frames: every pixel ends a frame; frame_count wraps
      b.img_out_empty = 1'b0;
      b.img_out_dout  = 8'h55;
      @(negedge clk);
      rst_b = 1'b0;
      n = 0;
      while (b.frame_count != 16'hFFFF && n < 70000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reach", b.frame_count, 16'hFFFF);
      chk("t6_eov", b.end_of_video_out, 1'b1);
      chk("t6_data", b.data_out, 24'h555555);
      chk("t6_busy", b.frame_busy, 1'b0);
      b.img_out_empty = 1'b1;
      @(negedge clk);
      chk("t6_wrap", b.frame_count, 16'h0000);
      chk("t6_drain", b.write, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
